// File: rtl/vrf_pkg.sv
// vrf_pkg: shared widths and write-request layout for the lane VRF write port
package vrf_pkg;
  localparam int VD_WIDTH = 5;
  localparam int OFFSET_WIDTH = 6;
  localparam int DATA_WIDTH = 32;
  localparam int INST_WIDTH = 3;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_WIDTH = VD_WIDTH + OFFSET_WIDTH;
  localparam int NUM_INST = 1 << INST_WIDTH;
  typedef logic [ADDR_WIDTH-1:0] vrf_addr_t;
  typedef struct packed {
    logic [VD_WIDTH-1:0] vd;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [MASK_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] data;
    logic last;
    logic [INST_WIDTH-1:0] instructionIndex;
  } vrf_write_req_t;
endpackage

// File: rtl/vrf_write_buffer.sv
// vrf_write_buffer: small FIFO of write requests, ready derived from registered occupancy only
module vrf_write_buffer import vrf_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  vrf_write_req_t req_i,
  input  logic           pop_i,
  output logic           ready_o,
  output logic           head_valid_o,
  output vrf_write_req_t head_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);
  vrf_write_req_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q;
  assign ready_o = cnt_q != FULL_CNT;
  assign head_valid_o = cnt_q != '0;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q == LAST_PTR ? '0 : wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q == LAST_PTR ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + NW'(push_i) - NW'(pop_i);
    end
  // storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_q] <= req_i;
endmodule

// File: rtl/vrf_write_port.sv
// vrf_write_port: buffers VRF write requests, arbitrates them against bank reads (read first,
// starvation override) and tracks per-instruction outstanding writes
module vrf_write_port import vrf_pkg::*; #(
  parameter int BUFFER_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    vrfWriteRequest_valid,
  output logic                    vrfWriteRequest_ready,
  input  logic [VD_WIDTH-1:0]     vrfWriteRequest_bits_vd,
  input  logic [OFFSET_WIDTH-1:0] vrfWriteRequest_bits_offset,
  input  logic [MASK_WIDTH-1:0]   vrfWriteRequest_bits_mask,
  input  logic [DATA_WIDTH-1:0]   vrfWriteRequest_bits_data,
  input  logic                    vrfWriteRequest_bits_last,
  input  logic [INST_WIDTH-1:0]   vrfWriteRequest_bits_instructionIndex,
  input  logic                    readRequest_valid,
  output logic                    readRequest_ready,
  output logic                    ramWrite_enable,
  output logic [ADDR_WIDTH-1:0]   ramWrite_address,
  output logic [MASK_WIDTH-1:0]   ramWrite_mask,
  output logic [DATA_WIDTH-1:0]   ramWrite_data,
  output logic                    writeComplete_valid,
  output logic [INST_WIDTH-1:0]   writeComplete_instructionIndex,
  output logic [NUM_INST-1:0]     instructionBusy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(BUFFER_DEPTH + 2);
  localparam logic [SW-1:0] STALL_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  vrf_write_req_t req, head;
  logic head_valid, push, issue, starved;
  logic [SW-1:0] stall_q, stall_d;
  logic ram_en_q, wc_valid_q, retire_q;
  vrf_addr_t addr_q;
  logic [MASK_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [INST_WIDTH-1:0] idx_q;
  logic [NUM_INST-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_INST-1:0] busy_q, busy_d, inc, dec;
  assign req = '{vd: vrfWriteRequest_bits_vd, offset: vrfWriteRequest_bits_offset,
                 mask: vrfWriteRequest_bits_mask, data: vrfWriteRequest_bits_data,
                 last: vrfWriteRequest_bits_last,
                 instructionIndex: vrfWriteRequest_bits_instructionIndex};
  assign push = vrfWriteRequest_valid & vrfWriteRequest_ready;
  vrf_write_buffer #(.DEPTH(BUFFER_DEPTH)) u_buf (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push),
    .req_i       (req),
    .pop_i       (issue),
    .ready_o     (vrfWriteRequest_ready),
    .head_valid_o(head_valid),
    .head_o      (head)
  );
  assign starved = head_valid && stall_q == STALL_MAX;
  assign issue = head_valid && (!readRequest_valid || starved);
  assign readRequest_ready = readRequest_valid && !starved;
  assign stall_d = !head_valid || issue ? '0 : (stall_q == STALL_MAX ? stall_q : stall_q + 1'b1);
  // counters retire in the RAM cycle, one cycle after the pop
  always_comb begin
    for (int k = 0; k < NUM_INST; k++) begin
      inc[k] = push && req.instructionIndex == INST_WIDTH'(k);
      dec[k] = retire_q && idx_q == INST_WIDTH'(k);
      cnt_d[k] = cnt_q[k] + CW'(inc[k]) - CW'(dec[k]);
      busy_d[k] = cnt_d[k] != '0;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stall_q <= '0;
      ram_en_q <= 1'b0;
      wc_valid_q <= 1'b0;
      retire_q <= 1'b0;
      addr_q <= '0;
      mask_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      busy_q <= '0;
    end else begin
      stall_q <= stall_d;
      ram_en_q <= issue && head.mask != '0;
      wc_valid_q <= issue && head.last;
      retire_q <= issue;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      if (issue) begin
        addr_q <= {head.vd, head.offset};
        mask_q <= head.mask;
        data_q <= head.data;
        idx_q <= head.instructionIndex;
      end
    end
  assign ramWrite_enable = ram_en_q;
  assign ramWrite_address = addr_q;
  assign ramWrite_mask = mask_q;
  assign ramWrite_data = data_q;
  assign writeComplete_valid = wc_valid_q;
  assign writeComplete_instructionIndex = idx_q;
  assign instructionBusy = busy_q;
  for (genvar i = 0; i < NUM_INST; i++) begin : g_cnt_chk
    assert property (@(posedge clock) disable iff (reset)
      !(inc[i] && !dec[i] && cnt_q[i] == CNT_MAX) && !(dec[i] && !inc[i] && cnt_q[i] == '0));
  end
endmodule

// File: tb/tb_vrf_write_port.sv
// tb_vrf_write_port: randomized and directed stimulus against a queue-based reference model
module tb_vrf_write_port;
  import vrf_pkg::*;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_ready, rd_valid = 1'b0, rd_ready, ram_en, wc_valid;
  vrf_write_req_t drv = '0;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [MASK_WIDTH-1:0] ram_mask;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [INST_WIDTH-1:0] wc_idx;
  logic [NUM_INST-1:0] busy;
  always #5 clock = ~clock;
  vrf_write_port dut (
    .clock(clock), .reset(reset),
    .vrfWriteRequest_valid(req_valid), .vrfWriteRequest_ready(req_ready),
    .vrfWriteRequest_bits_vd(drv.vd), .vrfWriteRequest_bits_offset(drv.offset),
    .vrfWriteRequest_bits_mask(drv.mask), .vrfWriteRequest_bits_data(drv.data),
    .vrfWriteRequest_bits_last(drv.last),
    .vrfWriteRequest_bits_instructionIndex(drv.instructionIndex),
    .readRequest_valid(rd_valid), .readRequest_ready(rd_ready),
    .ramWrite_enable(ram_en), .ramWrite_address(ram_addr), .ramWrite_mask(ram_mask),
    .ramWrite_data(ram_data), .writeComplete_valid(wc_valid),
    .writeComplete_instructionIndex(wc_idx), .instructionBusy(busy)
  );
  vrf_write_req_t q[$];
  vrf_write_req_t pending[$];
  vrf_write_req_t in_ram = '0;
  vrf_write_req_t idle = '0;
  logic in_ram_v = 1'b0;
  int waited = 0;
  int n_pass = 0, n_checks = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic vrf_write_req_t mk(input int vd, input int off, input int mask,
                                        input logic [31:0] data, input bit last, input int idx);
    vrf_write_req_t r;
    r.vd = VD_WIDTH'(vd);
    r.offset = OFFSET_WIDTH'(off);
    r.mask = MASK_WIDTH'(mask);
    r.data = data;
    r.last = last;
    r.instructionIndex = INST_WIDTH'(idx);
    return r;
  endfunction
  function automatic vrf_write_req_t rnd();
    return mk($urandom, $urandom, $urandom_range(3) == 0 ? 0 : $urandom, $urandom,
              $urandom_range(1) == 1, $urandom);
  endfunction
  // one cycle: drive at negedge, compare at negedge+1, advance the model, return at next negedge
  task automatic step(input logic v, input vrf_write_req_t r, input logic rv, output logic acc);
    logic [NUM_INST-1:0] exp_busy;
    logic hv, starved, issue;
    req_valid = v;
    drv = r;
    rd_valid = rv;
    #1;
    exp_busy = '0;
    foreach (q[k]) exp_busy[q[k].instructionIndex] = 1'b1;
    if (in_ram_v) exp_busy[in_ram.instructionIndex] = 1'b1;
    hv = q.size() > 0;
    starved = hv && waited >= LIMIT;
    issue = hv && (!rv || starved);
    acc = v && q.size() < DEPTH;
    check("req_ready", req_ready, q.size() < DEPTH);
    check("rd_ready", rd_ready, rv && !starved);
    check("ram_en", ram_en, in_ram_v && in_ram.mask != 0);
    if (in_ram_v && in_ram.mask != 0) begin
      check("ram_addr", ram_addr, {in_ram.vd, in_ram.offset});
      check("ram_mask", ram_mask, in_ram.mask);
      check("ram_data", ram_data, in_ram.data);
    end
    check("wc_valid", wc_valid, in_ram_v && in_ram.last);
    if (in_ram_v && in_ram.last) check("wc_idx", wc_idx, in_ram.instructionIndex);
    check("busy", busy, exp_busy);
    in_ram_v = issue;
    if (issue) in_ram = q.pop_front();
    waited = issue || !hv ? 0 : waited + 1;
    if (acc) q.push_back(r);
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic drive(input int max_cycles, input int rd_pct, input int vld_pct);
    logic acc, v;
    for (int c = 0; c < max_cycles && (pending.size() > 0 || q.size() > 0 || in_ram_v); c++) begin
      v = pending.size() > 0 && $urandom_range(99) < vld_pct;
      step(v, v ? pending[0] : idle, $urandom_range(99) < rd_pct, acc);
      if (acc) void'(pending.pop_front());
    end
    check("drained", pending.size() + q.size() + int'(in_ram_v), 0);
  endtask
  initial begin
    logic acc;
    @(negedge clock);
    check("rst_ready", req_ready, 1);
    check("rst_ram_en", ram_en, 0);
    check("rst_wc", wc_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    pending.push_back(mk(3, 5, 4'hF, 32'hDEADBEEF, 1, 2));
    drive(20, 0, 100);
    check("single_addr", ram_addr, 11'h0C5);
    for (int i = 0; i < 3; i++) pending.push_back(mk(i + 1, i, 4'hF, 32'h100 + i, i == 2, 1));
    drive(40, 100, 100);
    for (int i = 0; i < 6; i++) pending.push_back(rnd());
    drive(100, 70, 100);
    pending.push_back(mk(9, 9, 0, 32'h5555AAAA, 1, 7));
    drive(20, 0, 100);
    for (int i = 0; i < 80; i++) pending.push_back(rnd());
    drive(2000, 60, 70);
    pending.push_back(mk(1, 1, 4'h3, 32'h11, 0, 4));
    pending.push_back(mk(2, 2, 4'hC, 32'h22, 1, 4));
    repeat (3) begin
      step(pending.size() > 0, pending.size() > 0 ? pending[0] : idle, 1'b1, acc);
      if (acc) void'(pending.pop_front());
    end
    req_valid = 1'b0;
    rd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_ram_en", ram_en, 0);
    check("arst_wc", wc_valid, 0);
    check("arst_busy", busy, 0);
    q.delete();
    pending.delete();
    in_ram_v = 1'b0;
    waited = 0;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) step(1'b0, idle, 1'b0, acc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vrf_write_port.md
Name: vrf_write_port

Overview:
- Lane-side VRF write sink: the receiving end of the vrfWriteRequest ready/valid channel driven by the lane's stage-3 write queue.
- Buffers incoming write requests and arbitrates them against VRF reads for the single-port bank, read first with an anti-starvation override.
- Drives the bank's byte-masked write port.
- Tracks outstanding writes per instruction and reports per-instruction busy status plus write-completion pulses to lane control.

Parameters:
- VD_WIDTH, 5, vector register index width
- OFFSET_WIDTH, 6, word offset within one register slice
- DATA_WIDTH, 32, write data width; mask width = DATA_WIDTH/8
- INST_WIDTH, 3, instructionIndex width; 2^INST_WIDTH instruction slots
- BUFFER_DEPTH, 2, request buffer entries
- STARVE_LIMIT, 4, consecutive write-stall cycles before the write wins arbitration

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- vrfWriteRequest_valid  in  1  request valid
- vrfWriteRequest_ready  out  1  buffer can accept
- vrfWriteRequest_bits_vd  in  VD_WIDTH  target register
- vrfWriteRequest_bits_offset  in  OFFSET_WIDTH  word offset
- vrfWriteRequest_bits_mask  in  DATA_WIDTH/8  byte enables
- vrfWriteRequest_bits_data  in  DATA_WIDTH  write data
- vrfWriteRequest_bits_last  in  1  final write of the instruction
- vrfWriteRequest_bits_instructionIndex  in  INST_WIDTH  owning instruction
- readRequest_valid  in  1  bank read request this cycle
- readRequest_ready  out  1  read granted this cycle
- ramWrite_enable  out  1  bank write strobe
- ramWrite_address  out  VD_WIDTH+OFFSET_WIDTH  {vd, offset}
- ramWrite_mask  out  DATA_WIDTH/8  byte enables
- ramWrite_data  out  DATA_WIDTH  write data
- writeComplete_valid  out  1  one-cycle pulse when a last write retires
- writeComplete_instructionIndex  out  INST_WIDTH  retiring instruction
- instructionBusy  out  2^INST_WIDTH  bit i set while instruction i has buffered or in-flight writes

Behaviour:
- Reset (async assert, sync release):
  - buffer empties and all counters clear;
  - all outputs go to 0 except vrfWriteRequest_ready, which is 1 after reset;
  - reset mid-operation discards buffered writes; no writeComplete is emitted for them.
- Accept: handshake when valid & ready. vrfWriteRequest_ready = buffer not full, registered state only; it does not depend combinationally on readRequest_valid or on a same-cycle pop.
  - Full buffer with a pop in the same cycle: ready stays 0 that cycle.
  - Empty buffer: a request accepted at edge E0 is at the head in the following cycle; there is no bypass.
- Arbitration each cycle, with head valid:
  - Write issues if readRequest_valid=0, or if stallCount == STARVE_LIMIT.
  - readRequest_ready = readRequest_valid & ~(head valid & stallCount == STARVE_LIMIT).
  - stallCount increments on each cycle the head is blocked by a read, resets to 0 on issue, and saturates at STARVE_LIMIT.
  - With an empty buffer, readRequest_ready = readRequest_valid.
- Issue pipeline:
  - A head issued in cycle C is popped at the end of C.
  - The ramWrite_* registers load it, and they are visible in cycle C+1 with ramWrite_enable=1 for exactly one cycle.
  - Minimum latency from accept handshake to ramWrite_enable is 2 cycles.
- Zero-mask write: popped and counted normally, but ramWrite_enable stays 0. If last=1, writeComplete still pulses.
- Address: ramWrite_address = {vd, offset}, a concatenation with no arithmetic.
- Completion: writeComplete_valid=1 in the same cycle as the ramWrite_* for an issued entry with last=1, carrying that entry's instructionIndex.
- Per-instruction counters:
  - One counter per slot, width clog2(BUFFER_DEPTH+2).
  - Increment on accept; decrement when the issued entry's RAM cycle completes (cycle C+1).
  - Accept and retire for the same slot in the same cycle leave the counter unchanged.
  - instructionBusy[i] = (counter[i] != 0), registered.
  - Counter overflow/underflow is impossible by construction; an assertion checks it.
- Ordering: writes retire strictly in acceptance order. Bank RAW ordering against reads is the issuer's responsibility.

Decomposition:
- Shared package vrf_pkg holds:
  - width localparams VD_WIDTH, OFFSET_WIDTH, DATA_WIDTH, INST_WIDTH;
  - packed struct vrf_write_req_t {vd, offset, mask, data, last, instructionIndex}, matching the stage-3 dequeue layout;
  - typedef vrf_addr_t.
- Sub-module vrf_write_buffer: a BUFFER_DEPTH-entry FIFO of vrf_write_req_t with full/empty, registered ready, pop-by-head.
- Arbitration, counters and output registers stay in the top.

Test Plan:
- After reset, single write vd=3, offset=5, mask=4'hF, data=32'hDEADBEEF, last=1, idx=2, no reads:
  - ramWrite_enable high 2 cycles after accept with address 11'h0C5;
  - writeComplete_valid pulses with idx=2 in the same cycle;
  - instructionBusy[2] is 1 from accept+1 until the cycle after the write.
- Three back-to-back requests with readRequest_valid held 1:
  - ready drops after 2 accepts;
  - first write issues on the 5th stall cycle with readRequest_ready=0 that cycle;
  - stallCount then restarts and the remaining writes each wait 4 further stall cycles.
- Continuous reads interleaved with gaps: every gap cycle issues exactly one write, and data order matches acceptance order.
- Zero-mask write with last=1, idx=7: no ramWrite_enable; writeComplete pulses with idx=7; instructionBusy[7] clears.
- Simultaneous accept and retire for idx=1 with the buffer holding one idx=1 entry: counter[1] is unchanged and instructionBusy[1] stays 1.
- Reset asserted asynchronously with 2 buffered entries: ramWrite_enable, writeComplete_valid and instructionBusy go to 0 immediately; after release ready=1 and no stale write issues.
